// File: rtl/digit_serial_adder.sv
// Digit-serial adder: {cout,sum} = a + b + cin, two bits per clock through one 2-bit ripple slice.
// Latency: out_valid rises WIDTH/2 cycles after the input handshake; one operation in flight at a time.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module digit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int DIGITS = WIDTH / 2;
    localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_next;
    logic             s0, c0, s1, c1;
    logic             last_digit;

    // Two full adders rippling low digit bit into high digit bit.
    assign s0 = a_sr[0] ^ b_sr[0] ^ carry;
    assign c0 = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    assign s1 = a_sr[1] ^ b_sr[1] ^ c0;
    assign c1 = (a_sr[1] & b_sr[1]) | (c0 & (a_sr[1] ^ b_sr[1]));

    // Sum digits enter a_sr from the top as operand digits leave the bottom,
    // so after DIGITS shifts a_sr holds the complete sum.
    generate
        if (WIDTH == 2) begin : g_one_digit
            assign sum_next = {s1, s0};
        end else begin : g_multi_digit
            assign sum_next = {s1, s0, a_sr[WIDTH-1:2]};
        end
    endgenerate

    assign last_digit = (cnt == CW'(DIGITS - 1));

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign busy      = (state == ADD) || (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            carry <= 1'b0;
            a_sr  <= '0;
            b_sr  <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= ADD;
                    end
                end
                ADD: begin
                    a_sr  <= sum_next;
                    b_sr  <= b_sr >> 2;
                    carry <= c1;
                    cnt   <= cnt + CW'(1);
                    if (last_digit) begin
                        sum   <= sum_next;
                        cout  <= c1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed and random checks of digit_serial_adder at WIDTH 2, 8 and 16.
module tb_digit_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        iv2, ir2, ov2, or2, c2, co2, bz2;
    logic [1:0]  a2, b2, s2;
    logic        iv8, ir8, ov8, or8, c8, co8, bz8;
    logic [7:0]  a8, b8, s8;
    logic        iv16, ir16, ov16, or16, c16, co16, bz16;
    logic [15:0] a16, b16, s16;

    int passed = 0;
    int failed = 0;

    digit_serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .cin(c2),
        .out_valid(ov2), .out_ready(or2), .sum(s2), .cout(co2), .busy(bz2));
    digit_serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(c8),
        .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .busy(bz8));
    digit_serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .cin(c16),
        .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16), .busy(bz16));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_ir(input int w);
        case (w)
            2:       return ir2;
            8:       return ir8;
            default: return ir16;
        endcase
    endfunction

    function automatic logic get_ov(input int w);
        case (w)
            2:       return ov2;
            8:       return ov8;
            default: return ov16;
        endcase
    endfunction

    function automatic logic get_co(input int w);
        case (w)
            2:       return co2;
            8:       return co8;
            default: return co16;
        endcase
    endfunction

    function automatic logic [15:0] get_sum(input int w);
        case (w)
            2:       return {14'd0, s2};
            8:       return {8'd0, s8};
            default: return s16;
        endcase
    endfunction

    task automatic drive(input int w, input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic c);
        case (w)
            2:       begin iv2 = v;  a2 = a[1:0];  b2 = b[1:0];  c2 = c;  end
            8:       begin iv8 = v;  a8 = a[7:0];  b8 = b[7:0];  c8 = c;  end
            default: begin iv16 = v; a16 = a;      b16 = b;      c16 = c; end
        endcase
    endtask

    // One complete operation with out_ready held high; checks latency, result and release.
    task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input string tag);
        logic [15:0] mask;
        logic [16:0] full;
        int k;
        mask = (w == 16) ? 16'hFFFF : ((16'd1 << w) - 16'd1);
        k = 0;
        while (!get_ir(w) && k < 40) begin step(); k++; end
        chk({tag, " in_ready"}, 32'(get_ir(w)), 32'd1);
        drive(w, 1'b1, a & mask, b & mask, c);
        step();
        drive(w, 1'b0, 16'd0, 16'd0, 1'b0);
        k = 0;
        while (!get_ov(w) && k < 40) begin step(); k++; end
        chk({tag, " latency"}, 32'(k), 32'(w / 2));
        full = {1'b0, a & mask} + {1'b0, b & mask} + {16'd0, c};
        chk({tag, " sum"}, 32'(get_sum(w)), 32'(full[15:0] & mask));
        chk({tag, " cout"}, 32'(get_co(w)), 32'(full[w]));
        step();
        chk({tag, " release"}, 32'(get_ov(w)), 32'd0);
    endtask

    initial begin
        int k;
        int seen;
        rst = 1'b1;
        or2 = 1'b1; or8 = 1'b1; or16 = 1'b1;
        drive(2, 1'b0, 16'd0, 16'd0, 1'b0);
        drive(8, 1'b0, 16'd0, 16'd0, 1'b0);
        drive(16, 1'b0, 16'd0, 16'd0, 1'b0);
        step();
        step();

        chk("rst out_valid", 32'(ov8), 32'd0);
        chk("rst busy", 32'(bz8), 32'd0);
        chk("rst sum", 32'(s8), 32'd0);
        chk("rst cout", 32'(co8), 32'd0);
        chk("rst in_ready_in_rst", 32'(ir8), 32'd0);
        rst = 1'b0;
        #1;
        chk("idle in_ready", 32'(ir8), 32'd1);

        run_op(8, 16'h5A, 16'h3C, 1'b0, "add_5a_3c");
        chk("t1 idle in_ready", 32'(ir8), 32'd1);
        run_op(8, 16'hFF, 16'h01, 1'b0, "add_ff_01");
        run_op(8, 16'hFF, 16'hFF, 1'b1, "add_ff_ff_1");

        // Abandon an operation during its second ADD cycle.
        drive(8, 1'b1, 16'hAA, 16'h55, 1'b0);
        step();
        drive(8, 1'b0, 16'd0, 16'd0, 1'b0);
        step();
        rst = 1'b1;
        step();
        chk("midrst out_valid", 32'(ov8), 32'd0);
        chk("midrst sum", 32'(s8), 32'd0);
        chk("midrst cout", 32'(co8), 32'd0);
        chk("midrst busy", 32'(bz8), 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst in_ready", 32'(ir8), 32'd1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (ov8) seen++;
            step();
        end
        chk("midrst no result", 32'(seen), 32'd0);
        run_op(8, 16'h03, 16'h04, 1'b0, "after_rst_03_04");

        // Backpressure: hold result for 5 cycles.
        or8 = 1'b0;
        drive(8, 1'b1, 16'h12, 16'h34, 1'b1);
        step();
        drive(8, 1'b0, 16'd0, 16'd0, 1'b0);
        k = 0;
        while (!ov8 && k < 40) begin step(); k++; end
        chk("bp latency", 32'(k), 32'd4);
        for (int i = 0; i < 5; i++) begin
            chk("bp out_valid", 32'(ov8), 32'd1);
            chk("bp sum", 32'(s8), 32'h47);
            chk("bp cout", 32'(co8), 32'd0);
            chk("bp in_ready", 32'(ir8), 32'd0);
            chk("bp busy", 32'(bz8), 32'd1);
            step();
        end
        chk("bp still held", 32'(ov8), 32'd1);
        or8 = 1'b1;
        step();
        chk("bp released", 32'(ov8), 32'd0);
        chk("bp idle in_ready", 32'(ir8), 32'd1);

        // Back-to-back with in_valid held high.
        drive(8, 1'b1, 16'h01, 16'h01, 1'b0);
        step();
        drive(8, 1'b1, 16'h80, 16'h80, 1'b0);
        chk("b2b add in_ready", 32'(ir8), 32'd0);
        k = 0;
        while (!ov8 && k < 40) begin step(); k++; end
        chk("b2b r1 latency", 32'(k), 32'd4);
        chk("b2b r1 sum", 32'(s8), 32'h02);
        chk("b2b r1 cout", 32'(co8), 32'd0);
        step();
        chk("b2b gap out_valid", 32'(ov8), 32'd0);
        chk("b2b gap in_ready", 32'(ir8), 32'd1);
        step();
        drive(8, 1'b0, 16'd0, 16'd0, 1'b0);
        chk("b2b r2 accepted", 32'(bz8), 32'd1);
        k = 0;
        while (!ov8 && k < 40) begin step(); k++; end
        chk("b2b r2 latency", 32'(k), 32'd4);
        chk("b2b r2 sum", 32'(s8), 32'h00);
        chk("b2b r2 cout", 32'(co8), 32'd1);
        step();
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (ov8) seen++;
            step();
        end
        chk("b2b no third result", 32'(seen), 32'd0);

        run_op(2, 16'd3, 16'd3, 1'b1, "w2_3_3_1");
        run_op(2, 16'd1, 16'd2, 1'b0, "w2_1_2_0");

        for (int i = 0; i < 1000; i++)
            run_op(8, 16'($urandom), 16'($urandom), 1'($urandom), "rand8");
        for (int i = 0; i < 1000; i++)
            run_op(16, 16'($urandom), 16'($urandom), 1'($urandom), "rand16");

        $display("%0d/%0d checks passed", passed, passed + failed);
        $finish;
    end

endmodule
